// File: rtl/median_window_ctrl.sv
// Sliding-window controller for an external, purely combinational N-input median sorting network.
// Define MEDIAN_MINMAX_EN to add registered window minimum/maximum outputs (out_min/out_max).
module median_window_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 11,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic [N*WIDTH-1:0] net_data,
  input  logic [N*WIDTH-1:0] net_sort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
`ifdef MEDIAN_MINMAX_EN
  output logic [WIDTH-1:0]   out_min,
  output logic [WIDTH-1:0]   out_max,
`endif
  output logic [CNT_W-1:0]   result_cnt
);

  localparam int unsigned       FILL_W    = $clog2(N + 1);
  localparam int unsigned       MID       = N / 2;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(N - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);

  typedef enum logic [1:0] {
    S_FILL,
    S_EVAL,
    S_HOLD,
    S_RUN
  } state_t;

  state_t             state_q, state_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [N*WIDTH-1:0] win_q, win_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
`ifdef MEDIAN_MINMAX_EN
  logic [WIDTH-1:0]   min_q, min_d;
  logic [WIDTH-1:0]   max_q, max_d;
`endif

  // Only the slots captured below are consumed; the rest of the network output is don't-care.
  logic unused_sort_bits;
  assign unused_sort_bits = ^net_sort;

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      S_FILL:  in_ready = 1'b1;
      S_RUN:   in_ready = 1'b1;
      S_EVAL:  in_ready = 1'b0;
      S_HOLD:  in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    if (flush) in_ready = 1'b0;
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    win_d       = win_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cnt_d       = cnt_q;
`ifdef MEDIAN_MINMAX_EN
    min_d       = min_q;
    max_d       = max_q;
`endif

    if (accept) win_d = {win_q[(N-1)*WIDTH-1:0], in_data};

    unique case (state_q)
      S_FILL: begin
        if (accept) begin
          if (fill_q == FILL_LAST) begin
            fill_d  = FILL_FULL;
            state_d = S_EVAL;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
      end
      S_EVAL: begin
        out_data_d  = net_sort[MID*WIDTH +: WIDTH];
`ifdef MEDIAN_MINMAX_EN
        min_d       = net_sort[0 +: WIDTH];
        max_d       = net_sort[(N-1)*WIDTH +: WIDTH];
`endif
        out_valid_d = 1'b1;
        cnt_d       = cnt_q + 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = in_valid ? S_EVAL : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) state_d = S_EVAL;
      end
      default: state_d = S_FILL;
    endcase

    // Flush clears the window and any pending result but keeps the last result and the count.
    if (flush) begin
      state_d     = S_FILL;
      fill_d      = '0;
      win_d       = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FILL;
      fill_q      <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= '0;
`ifdef MEDIAN_MINMAX_EN
      min_q       <= '0;
      max_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
`ifdef MEDIAN_MINMAX_EN
      min_q       <= min_d;
      max_q       <= max_d;
`endif
    end
  end

  assign net_data   = win_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign result_cnt = cnt_q;
`ifdef MEDIAN_MINMAX_EN
  assign out_min    = min_q;
  assign out_max    = max_q;
`endif

endmodule

// File: tb/tb_median_window_ctrl.sv
// Directed bench for median_window_ctrl with a behavioural ascending-sort network model.
// Define MEDIAN_MINMAX_EN to also check out_min/out_max.
module tb_median_window_ctrl;

  localparam int unsigned W  = 32;
  localparam int unsigned NN = 11;
  localparam int unsigned CW = 4;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic [NN*W-1:0] net_data;
  logic [NN*W-1:0] net_sort;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [CW-1:0]   result_cnt;
`ifdef MEDIAN_MINMAX_EN
  logic [W-1:0]    out_min;
  logic [W-1:0]    out_max;
`endif

  int checks = 0;
  int errors = 0;

  median_window_ctrl #(.WIDTH(W), .N(NN), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .net_data  (net_data),
    .net_sort  (net_sort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef MEDIAN_MINMAX_EN
    .out_min   (out_min),
    .out_max   (out_max),
`endif
    .result_cnt(result_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for the external sorting network: unsigned ascending sort.
  function automatic logic [NN*W-1:0] sort_net(input logic [NN*W-1:0] d);
    logic [W-1:0]    a [NN];
    logic [W-1:0]    t;
    logic [NN*W-1:0] r;
    for (int i = 0; i < NN; i++) a[i] = d[i*W +: W];
    for (int i = 0; i < NN - 1; i++)
      for (int j = 0; j < NN - 1 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    for (int i = 0; i < NN; i++) r[i*W +: W] = a[i];
    return r;
  endfunction

  assign net_sort = sort_net(net_data);

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    int unsigned guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && guard < 50) begin step(); guard++; end
    if (!in_ready) begin
      errors++; $display("FAIL push_timeout in_ready=%0b required=1", in_ready);
    end
    checks++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    step();
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", out_valid); end checks++;
    if (out_data !== '0) begin errors++; $display("FAIL rst_data got %h want 0", out_data); end checks++;
    if (result_cnt !== '0) begin errors++; $display("FAIL rst_cnt got %0d want 0", result_cnt); end checks++;
    if (net_data !== '0) begin errors++; $display("FAIL rst_window got %h want 0", net_data); end checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b want 1", in_ready); end checks++;
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 11; i++) begin
      push(W'(i));
      if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_valid_%0d got %0b want 0", i, out_valid); end checks++;
    end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL eval_ready got %0b want 0", in_ready); end checks++;
    if (net_data[0 +: W] !== 32'd11) begin errors++; $display("FAIL slot0 got %0d want 11", net_data[0 +: W]); end checks++;
    if (net_data[10*W +: W] !== 32'd1) begin errors++; $display("FAIL slot10 got %0d want 1", net_data[10*W +: W]); end checks++;
    step();
    if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %0b want 1", out_valid); end checks++;
    if (out_data !== 32'd6) begin errors++; $display("FAIL first_median got %0d want 6", out_data); end checks++;
    if (result_cnt !== 4'd1) begin errors++; $display("FAIL first_cnt got %0d want 1", result_cnt); end checks++;
  endtask

  task automatic test_continue();
    push(32'd12);
    if (in_ready !== 1'b0) begin errors++; $display("FAIL eval2_ready got %0b want 0", in_ready); end checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL eval2_valid got %0b want 0", out_valid); end checks++;
    step();
    if (out_data !== 32'd7) begin errors++; $display("FAIL second_median got %0d want 7", out_data); end checks++;
    if (result_cnt !== 4'd2) begin errors++; $display("FAIL second_cnt got %0d want 2", result_cnt); end checks++;
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd13;
    #1;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready0 got %0b want 0", in_ready); end checks++;
    for (int c = 0; c < 5; c++) begin
      step();
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d got %0b want 0", c, in_ready); end checks++;
      if (out_valid !== 1'b1 || out_data !== 32'd7) begin
        errors++; $display("FAIL bp_hold_%0d got v=%0b d=%0d want v=1 d=7", c, out_valid, out_data);
      end checks++;
    end
    out_ready = 1'b1;
    #1;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %0b want 1", in_ready); end checks++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_eval_valid got %0b want 0", out_valid); end checks++;
    step();
    if (out_data !== 32'd8) begin errors++; $display("FAIL bp_median got %0d want 8", out_data); end checks++;
    if (result_cnt !== 4'd3) begin errors++; $display("FAIL bp_cnt got %0d want 3", result_cnt); end checks++;
  endtask

  task automatic test_flush_pending();
    out_ready = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b1;
    #1;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", out_valid); end checks++;
    if (out_data !== 32'd8) begin errors++; $display("FAIL flush_keep_data got %0d want 8", out_data); end checks++;
    if (result_cnt !== 4'd3) begin errors++; $display("FAIL flush_keep_cnt got %0d want 3", result_cnt); end checks++;
    if (net_data !== '0) begin errors++; $display("FAIL flush_window got %h want 0", net_data); end checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b want 1", in_ready); end checks++;
  endtask

  task automatic test_unsigned();
    for (int i = 0; i < 11; i++) push(32'hFFFF_FFFF);
    step();
    if (out_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL max_median got %h want ffffffff", out_data); end checks++;
    if (result_cnt !== 4'd4) begin errors++; $display("FAIL max_cnt got %0d want 4", result_cnt); end checks++;
    push(32'd0);
    step();
    if (out_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL zero_median got %h want ffffffff", out_data); end checks++;
    if (result_cnt !== 4'd5) begin errors++; $display("FAIL zero_cnt got %0d want 5", result_cnt); end checks++;
`ifdef MEDIAN_MINMAX_EN
    if (out_min !== 32'd0) begin errors++; $display("FAIL out_min got %h want 0", out_min); end checks++;
    if (out_max !== 32'hFFFF_FFFF) begin errors++; $display("FAIL out_max got %h want ffffffff", out_max); end checks++;
`endif
  endtask

  task automatic test_flush_accept();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 7; i++) push(W'(100 + i));
    flush = 1'b1; in_valid = 1'b1; in_data = 32'd999;
    #1;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_acc_ready got %0b want 0", in_ready); end checks++;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    if (net_data !== '0) begin errors++; $display("FAIL flush_acc_window got %h want 0", net_data); end checks++;
    for (int i = 1; i <= 10; i++) push(W'(200 + i));
    step(); step();
    if (out_valid !== 1'b0) begin errors++; $display("FAIL partial_valid got %0b want 0", out_valid); end checks++;
    push(32'd211);
    if (out_valid !== 1'b0) begin errors++; $display("FAIL refill_eval_valid got %0b want 0", out_valid); end checks++;
    if (net_data[10*W +: W] !== 32'd201) begin errors++; $display("FAIL refill_oldest got %0d want 201", net_data[10*W +: W]); end checks++;
    step();
    if (out_valid !== 1'b1 || out_data !== 32'd206) begin
      errors++; $display("FAIL refill_median got v=%0b d=%0d want v=1 d=206", out_valid, out_data);
    end checks++;
    if (result_cnt !== 4'd6) begin errors++; $display("FAIL refill_cnt got %0d want 6", result_cnt); end checks++;
  endtask

  task automatic test_async_reset();
    logic [W-1:0] vals [11];
    vals = '{32'd9, 32'd3, 32'd7, 32'd1, 32'd11, 32'd5, 32'd2, 32'd10, 32'd4, 32'd8, 32'd6};
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %0b want 0", out_valid); end checks++;
    if (out_data !== '0) begin errors++; $display("FAIL arst_data got %h want 0", out_data); end checks++;
    if (result_cnt !== '0) begin errors++; $display("FAIL arst_cnt got %0d want 0", result_cnt); end checks++;
    #1 rst = 1'b0;
    out_ready = 1'b1;
    step();
    if (out_valid !== 1'b0 || net_data !== '0) begin
      errors++; $display("FAIL arst_idle got v=%0b win=%h want v=0 win=0", out_valid, net_data);
    end checks++;
    for (int i = 0; i < 11; i++) begin
      push(vals[i]);
      if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_fill_%0d got %0b want 0", i, out_valid); end checks++;
    end
    step();
    if (out_data !== 32'd6) begin errors++; $display("FAIL arst_median got %0d want 6", out_data); end checks++;
    if (result_cnt !== 4'd1) begin errors++; $display("FAIL arst_refill_cnt got %0d want 1", result_cnt); end checks++;
  endtask

  task automatic test_cnt_wrap();
    for (int k = 1; k <= 15; k++) begin
      push(32'd6);
      step();
      if (out_valid !== 1'b1 || result_cnt !== CW'(k + 1)) begin
        errors++; $display("FAIL wrap_cnt_%0d got v=%0b cnt=%0d want v=1 cnt=%0d", k, out_valid, result_cnt, (k + 1) % 16);
      end checks++;
    end
    if (out_data !== 32'd6) begin errors++; $display("FAIL wrap_median got %0d want 6", out_data); end checks++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_continue();
    test_back_pressure();
    test_flush_pending();
    test_unsigned();
    test_flush_accept();
    test_async_reset();
    test_cnt_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached=1 required=0");
    $fatal(1);
  end

endmodule
